icache_fill_ctrl: RTL and testbench

Direct-mapped instruction cache with a block-fill state machine, inserted between IF's fetch port and the instruction memory block port. On a hit it returns the instruction combinationally. On a miss it stalls IF, issues one block read for the 32-byte line, installs the line and then replays the fetch. It also performs the whole-cache invalidate that the syscall flush sequence requires, and counts misses for performance reporting.

---
 rtl/icache_fill_ctrl_if.sv | 37 +++
 rtl/icache_fill_ctrl.sv | 121 ++++++++++++
 tb/tb_icache_fill_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_ctrl_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache fill controller.
// slave = the cache, master = the IF stage plus the instruction memory around it.
interface icache_fill_ctrl_if;
  logic [31:0]  Instr_address_2IC;
  logic [31:0]  Instr1_fIC;
  logic         Stall_2IF;
  logic [31:0]  Instr_address_2IM;
  logic         iBlkRead;
  logic [255:0] block_read_fIM;
  logic         block_read_fIM_valid;
  logic         Invalidate;
  logic [31:0]  Miss_count;

  modport slave (
    input  Instr_address_2IC,
    input  block_read_fIM,
    input  block_read_fIM_valid,
    input  Invalidate,
    output Instr1_fIC,
    output Stall_2IF,
    output Instr_address_2IM,
    output iBlkRead,
    output Miss_count
  );

  modport master (
    output Instr_address_2IC,
    output block_read_fIM,
    output block_read_fIM_valid,
    output Invalidate,
    input  Instr1_fIC,
    input  Stall_2IF,
    input  Instr_address_2IM,
    input  iBlkRead,
    input  Miss_count
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped flop-based instruction cache with 32-byte line fill, whole-cache
// invalidate and a saturating miss counter.
module icache_fill_ctrl #(
  parameter int unsigned LINES = 16
) (
  input logic               CLK,
  input logic               RESET,
  icache_fill_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = 32 - 5 - IDX_W;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic [31:0]         addr_q, addr_d;
  logic                blk_q, blk_d;
  logic [31:0]         miss_q, miss_d;

  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [2:0]          pc_word;
  logic [IDX_W-1:0]    fill_idx;
  logic [LINE_W-1:0]   pc_line;
  logic [WORD_W-1:0]   pc_instr;
  logic                hit;
  logic                install;

  assign pc_word  = bus.Instr_address_2IC[4:2];
  assign pc_idx   = bus.Instr_address_2IC[5 +: IDX_W];
  assign pc_tag   = bus.Instr_address_2IC[31 -: TAG_W];
  assign fill_idx = addr_q[5 +: IDX_W];

  // Lookup is purely combinational so a hit returns in the same cycle.
  always_comb begin
    pc_line  = data_q[pc_idx];
    pc_instr = pc_line[{pc_word, 5'b0} +: WORD_W];
    hit      = !RESET && (state_q == S_IDLE) && valid_q[pc_idx] &&
               (tag_q[pc_idx] == pc_tag) && !bus.Invalidate;
  end

  assign bus.Stall_2IF         = !hit;
  assign bus.Instr1_fIC        = hit ? pc_instr : '0;
  assign bus.Instr_address_2IM = addr_q;
  assign bus.iBlkRead          = blk_q;
  assign bus.Miss_count        = miss_q;

  // Next-state logic; Invalidate overrides any fill in progress or about to start.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    blk_d   = blk_q;
    miss_d  = miss_q;
    install = 1'b0;
    if (bus.Invalidate) begin
      valid_d = '0;
      state_d = S_IDLE;
      blk_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit) begin
            state_d = S_FILL;
            blk_d   = 1'b1;
            addr_d  = {bus.Instr_address_2IC[31:5], 5'b0};
            if (miss_q != '1) begin
              miss_d = miss_q + 32'd1;
            end
          end
        end
        S_FILL: begin
          if (bus.block_read_fIM_valid) begin
            install           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            state_d           = S_IDLE;
            blk_d             = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          blk_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      blk_q   <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      blk_q   <= blk_d;
      miss_q  <= miss_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (install && !RESET) begin
      tag_q[fill_idx]  <= addr_q[31 -: TAG_W];
      data_q[fill_idx] <= bus.block_read_fIM;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: vector table, directed corner sequences and random
// traffic checked against a line-level cache model.
module tb_icache_fill_ctrl;

  localparam int unsigned LINES = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  icache_fill_ctrl_if bus ();

  icache_fill_ctrl #(.LINES(LINES)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory content: a bijective scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  // Memory always presents the line at the requested address.
  always_comb bus.block_read_fIM = line_of(bus.Instr_address_2IM);

  // Reference model: which line address each index holds, plus an outstanding fill.
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_cnt;
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];

  logic        r_rst, r_inv, r_mv;
  logic [31:0] r_pc;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) % LINES);
  endfunction

  function automatic bit m_hit();
    return !r_rst && !m_busy && !r_inv && m_valid[idx_of(r_pc)] &&
           (m_line[idx_of(r_pc)] == {r_pc[31:5], 5'b0});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic inv, input logic mv);
    r_rst = rst; r_pc = pc; r_inv = inv; r_mv = mv;
    RESET = rst;
    bus.Instr_address_2IC    = pc;
    bus.Invalidate           = inv;
    bus.block_read_fIM_valid = mv;
    #1;
  endtask

  task automatic check_model();
    bit h;
    h = m_hit();
    chk("m_stall", 32'(bus.Stall_2IF), 32'(!h));
    chk("m_instr", bus.Instr1_fIC, h ? mem_word({r_pc[31:2], 2'b0}) : 32'h0);
    chk("m_blk", 32'(bus.iBlkRead), 32'(m_busy));
    chk("m_addr", bus.Instr_address_2IM, m_addr);
    chk("m_cnt", bus.Miss_count, m_cnt);
  endtask

  task automatic tick();
    bit h;
    h = m_hit();
    @(posedge CLK);
    if (r_rst) begin
      m_busy = 0; m_addr = '0; m_cnt = '0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (r_inv) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (r_mv) begin
        m_valid[idx_of(m_addr)] = 1;
        m_line[idx_of(m_addr)]  = m_addr;
        m_busy = 0;
      end
    end else if (!h) begin
      m_busy = 1;
      m_addr = {r_pc[31:5], 5'b0};
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    @(negedge CLK);
  endtask

  task automatic cyc(input logic rst, input logic [31:0] pc, input logic inv, input logic mv);
    drive(rst, pc, inv, mv);
    check_model();
    tick();
  endtask

  // Fetch pc until it hits; memory answers after lat FILL cycles.
  task automatic fetch(input logic [31:0] pc, input int lat, output int stalls);
    int w;
    bit done;
    w = 0; stalls = 0; done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      drive(1'b0, pc, 1'b0, m_busy && (w >= lat));
      check_model();
      if (!bus.Stall_2IF) begin
        done = 1;
        chk("fetch_instr", bus.Instr1_fIC, mem_word({pc[31:2], 2'b0}));
      end else begin
        stalls++;
      end
      if (m_busy) w++;
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: pc %h still stalled after %0d cycles", pc, stalls);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        mv;
    logic        stall;
    logic        blk;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic [31:0] instr;
  } vec_t;

  vec_t tv [13];

  logic [31:0] bases [6];

  initial begin
    int s;
    logic [31:0] pc;

    tv[0] = '{1'b1, 32'h0040_0000, 1'b0, 1'b1, 1'b0, 32'h0,         32'd0, 32'h0};
    tv[1] = '{1'b0, 32'h0040_0000, 1'b0, 1'b1, 1'b0, 32'h0,         32'd0, 32'h0};
    tv[2] = '{1'b0, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'd1, 32'h0};
    tv[3] = '{1'b0, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'd1, 32'h0};
    tv[4] = '{1'b0, 32'h0040_0000, 1'b1, 1'b1, 1'b1, 32'h0040_0000, 32'd1, 32'h0};
    for (int k = 0; k < 8; k++) begin
      pc = 32'h0040_0000 + 32'(4 * k);
      tv[5 + k] = '{1'b0, pc, 1'(k % 2), 1'b0, 1'b0, 32'h0040_0000, 32'd1, mem_word(pc)};
    end

    // Preamble reset edge so registers are defined before checking.
    drive(1'b1, 32'h0040_0000, 1'b0, 1'b0);
    tick();

    // Reset, first fetch with 3-cycle memory, then sequential hits.
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].pc, 1'b0, tv[i].mv);
      chk($sformatf("tv%0d_stall", i), 32'(bus.Stall_2IF), 32'(tv[i].stall));
      chk($sformatf("tv%0d_blk", i), 32'(bus.iBlkRead), 32'(tv[i].blk));
      chk($sformatf("tv%0d_addr", i), bus.Instr_address_2IM, tv[i].addr);
      chk($sformatf("tv%0d_cnt", i), bus.Miss_count, tv[i].cnt);
      chk($sformatf("tv%0d_instr", i), bus.Instr1_fIC, tv[i].instr);
      check_model();
      tick();
    end

    // Conflict eviction on index 0.
    cyc(1'b1, 32'h0040_0000, 1'b0, 1'b0);
    fetch(32'h0040_0000, 1, s); chk("evict_stall_a", 32'(s), 32'd3);
    fetch(32'h0040_0200, 0, s); chk("evict_stall_b", 32'(s), 32'd2);
    fetch(32'h0040_0000, 2, s); chk("evict_stall_c", 32'(s), 32'd4);
    chk("evict_cnt", bus.Miss_count, 32'd3);

    // Redirect during fill: the latched line completes, then the new PC fills.
    cyc(1'b0, 32'h0040_0020, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0040_0100, 1'b0, 1'(i == 2));
      chk("redir_addr_held", bus.Instr_address_2IM, 32'h0040_0020);
      check_model();
      tick();
    end
    cyc(1'b0, 32'h0040_0100, 1'b0, 1'b0);
    drive(1'b0, 32'h0040_0100, 1'b0, 1'b0);
    chk("redir_new_blk", 32'(bus.iBlkRead), 32'd1);
    chk("redir_new_addr", bus.Instr_address_2IM, 32'h0040_0100);
    check_model();
    tick();
    fetch(32'h0040_0100, 0, s);
    fetch(32'h0040_0020, 0, s); chk("redir_old_hits", 32'(s), 32'd0);

    // One-cycle invalidate: every resident line misses afterwards.
    cyc(1'b0, 32'h0040_0000, 1'b1, 1'b0);
    fetch(32'h0040_0000, 0, s); chk("inv_miss_a", 32'(s), 32'd2);
    fetch(32'h0040_0020, 0, s); chk("inv_miss_b", 32'(s), 32'd2);
    fetch(32'h0040_0100, 0, s); chk("inv_miss_c", 32'(s), 32'd2);

    // Invalidate coincident with the memory response installs nothing.
    cyc(1'b0, 32'h0040_0200, 1'b0, 1'b0);
    drive(1'b0, 32'h0040_0200, 1'b1, 1'b1);
    check_model();
    tick();
    drive(1'b0, 32'h0040_0200, 1'b0, 1'b0);
    chk("coinc_blk", 32'(bus.iBlkRead), 32'd0);
    chk("coinc_stall", 32'(bus.Stall_2IF), 32'd1);
    check_model();
    tick();
    fetch(32'h0040_0200, 0, s); chk("coinc_refill", 32'(s), 32'd1);
    fetch(32'h0040_0000, 0, s); chk("coinc_other_miss", 32'(s), 32'd2);

    // Spurious valids in reset, in IDLE and under Invalidate are ignored.
    cyc(1'b1, 32'h1000_0000, 1'b0, 1'b1);
    cyc(1'b1, 32'h1000_0000, 1'b0, 1'b1);
    cyc(1'b0, 32'h1000_0020, 1'b1, 1'b1);
    cyc(1'b0, 32'h1000_0020, 1'b1, 1'b1);
    chk("spur_cnt0", bus.Miss_count, 32'd0);
    cyc(1'b0, 32'h1000_0000, 1'b0, 1'b1);
    cyc(1'b0, 32'h1000_0000, 1'b0, 1'b0);
    cyc(1'b0, 32'h1000_0000, 1'b0, 1'b0);
    fetch(32'h1000_0000, 0, s); chk("spur_fill_stalls", 32'(s), 32'd1);
    chk("spur_cnt1", bus.Miss_count, 32'd1);

    // Reset during FILL discards a coincident response.
    cyc(1'b0, 32'h2000_0000, 1'b0, 1'b0);
    cyc(1'b0, 32'h2000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h2000_0000, 1'b0, 1'b1);
    drive(1'b0, 32'h2000_0000, 1'b0, 1'b0);
    chk("rstfill_blk", 32'(bus.iBlkRead), 32'd0);
    chk("rstfill_cnt", bus.Miss_count, 32'd0);
    chk("rstfill_addr", bus.Instr_address_2IM, 32'h0);
    check_model();
    tick();

    // Random traffic over a few conflicting and non-conflicting lines.
    bases[0] = 32'h0040_0000; bases[1] = 32'h0040_0200; bases[2] = 32'h0040_0020;
    bases[3] = 32'h0040_0100; bases[4] = 32'h1000_01E0; bases[5] = 32'h7FFF_FFE0;
    for (int i = 0; i < 3000; i++) begin
      pc = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 499) == 0), pc, 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
